seq_detect_prog: RTL and testbench
==================================

Name: seq_detect_prog

Overview:
- Parametrised successor to the fixed 5-bit serial sequence detector.
- Detects a runtime-programmable bit pattern of length 1..PAT_W in a serial bit stream qualified by a valid strobe.
- Supports overlapping and non-overlapping detection, and counts matches in a saturating counter.
- Sits between a serial bit source and a status/interrupt register bank.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width (>=1)
LEN_W, $clog2(PAT_W+1), width of pattern-length input (derived; do not override)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
in  input  1  serial data bit
in_valid  input  1  in is sampled only when high
load  input  1  latch pat/pat_len/overlap_en into config regs; clears history
pat  input  PAT_W  pattern; pat[pat_len-1] is received first, pat[0] last
pat_len  input  LEN_W  active pattern length
overlap_en  input  1  1 = overlapping matches, 0 = history restarts after a match
clr_cnt  input  1  zero match counter
out  output  1  one-cycle match pulse (registered)
match_cnt  output  CNT_W  saturating count of matches
cnt_sat  output  1  high while match_cnt is all ones
cfg_err  output  1  latched config length is 0 or >PAT_W

Behaviour:
- Reset (rst high at posedge):
  - Config regs: pat=0, len=0, overlap=0.
  - History register and fill counter cleared.
  - out=0, match_cnt=0, cnt_sat=0, cfg_err=1 (len 0 is invalid).
  - Applies mid-pattern; a partial match is discarded.
- Config:
  - On load, config regs take pat, pat_len and overlap_en.
  - cfg_err <= (pat_len==0 || pat_len>PAT_W).
  - History and fill counter are cleared.
  - If in_valid is also high that cycle, the bit is discarded. load has priority.
  - match_cnt is not affected by load.
- Shift path: on each posedge with in_valid=1, load=0 and rst=0:
  - hist <= {hist[PAT_W-2:0], in}.
  - fill <= min(fill+1, PAT_W).
  - Cycles with in_valid=0 change nothing; out=0.
- Match condition, evaluated on the bit being sampled:
  - cfg_err=0, fill+1 >= len, and the newest len bits of the next history value equal pat[len-1:0].
- Latency:
  - out=1 in the cycle immediately after the edge that samples the completing bit; exactly one cycle wide.
  - Back-to-back matches give consecutive out pulses.
- Overlap:
  - overlap=1: history is kept after a match.
  - overlap=0: the same edge that registers a match sets fill to 0, so the next match needs len fresh bits.
- Counter:
  - match_cnt increments on the same edge out is set and saturates at 2^CNT_W-1 (no wrap).
  - cnt_sat = (match_cnt == all ones).
  - clr_cnt sets match_cnt to 0 and wins over a simultaneous increment; the out pulse is still produced.
- Bits beyond len in hist are ignored. Bits of pat at index >= len are don't-care.
- While cfg_err=1: no matches and no counting; history still shifts.
- Encode fill as a counter of LEN_W bits. No latches; every register has an explicit reset value.

Test Plan:
1. rst; load pat=8'b00010110, pat_len=5, overlap_en=1. Stream 1,0,1,1,0,1,1,0 with in_valid=1 -> out pulses after bits 5 and 8 (1-based); match_cnt=2.
2. Same config with overlap_en=0, same stream -> single out pulse after bit 5; match_cnt=1; no pulse after bit 8.
3. pat_len=2, pat=..11, stream 1,1,1,1 -> overlap=1: pulses after bits 2,3,4, count 3; overlap=0: pulses after bits 2 and 4, count 2.
4. pat 10110 with in_valid=0 for 3 cycles between bits 3 and 4 -> single match after the 5th valid bit; out=0 throughout the gap cycles.
5. CNT_W=2 override, pat_len=1, pat=..1, six 1s -> match_cnt 1,2,3,3,3,3; cnt_sat=1 from the 3rd match. Then clr_cnt with a simultaneous match -> match_cnt=0 and out=1.
6. Feed 1,0,1,1, assert rst one cycle, reload config, feed 0 -> no match. load with pat_len=0 or PAT_W+1 -> cfg_err=1; stream 10110 gives no pulse.

Source files
------------

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector.
// Matches a runtime-loaded pattern of 1..PAT_W bits against a valid-qualified
// bit stream, with optional overlap and a saturating match counter.
module seq_detect_prog #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in,
    input  logic             i_in_valid,
    input  logic             i_load,
    input  logic [PAT_W-1:0] i_pat,
    input  logic [LEN_W-1:0] i_pat_len,
    input  logic             i_overlap_en,
    input  logic             i_clr_cnt,
    output logic             o_out,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic             o_cnt_sat,
    output logic             o_cfg_err
);

    localparam logic [LEN_W:0] PAT_W_X = (LEN_W + 1)'(PAT_W);

    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic             r_cfg_err;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic             r_out;
    logic [CNT_W-1:0] r_cnt;

    logic [PAT_W-1:0] w_hist_nxt;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W:0]   w_fill_p1;
    logic [LEN_W-1:0] w_fill_sat;
    logic             w_shift;
    logic             w_match;
    logic             w_cnt_full;

    assign w_hist_nxt = {r_hist[PAT_W-2:0], i_in};
    assign w_fill_p1  = {1'b0, r_fill} + 1'b1;
    assign w_fill_sat = (w_fill_p1 > PAT_W_X) ? PAT_W_X[LEN_W-1:0] : w_fill_p1[LEN_W-1:0];
    assign w_shift    = i_in_valid && !i_load;
    assign w_cnt_full = &r_cnt;

    // Select the active len bits of history; bits above len are ignored.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = ((LEN_W + 1)'(i) < {1'b0, r_len});
        end
    end

    // A match is judged on the history value that includes the bit being sampled.
    always_comb begin
        w_match = w_shift && !r_cfg_err
                  && (w_fill_p1 >= {1'b0, r_len})
                  && (((w_hist_nxt ^ r_pat) & w_mask) == '0);
    end

    // Configuration capture; load wins over a same-cycle data bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pat     <= '0;
            r_len     <= '0;
            r_ovl     <= 1'b0;
            r_cfg_err <= 1'b1;
        end else if (i_load) begin
            r_pat     <= i_pat;
            r_len     <= i_pat_len;
            r_ovl     <= i_overlap_en;
            r_cfg_err <= (i_pat_len == '0) || ({1'b0, i_pat_len} > PAT_W_X);
        end
    end

    // History shift and fill tracking; non-overlap mode restarts fill on a match.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_load) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (w_shift) begin
            r_hist <= w_hist_nxt;
            r_fill <= (w_match && !r_ovl) ? '0 : w_fill_sat;
        end
    end

    // Registered one-cycle match pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out <= 1'b0;
        end else begin
            r_out <= w_match;
        end
    end

    // Saturating match counter; clear beats a simultaneous increment.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr_cnt) begin
            r_cnt <= '0;
        end else if (w_match && !w_cnt_full) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_out       = r_out;
    assign o_match_cnt = r_cnt;
    assign o_cnt_sat   = w_cnt_full;
    assign o_cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: a default instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation checks.
module tb_seq_detect_prog;

    localparam int PAT_W = 8;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             rst, in_b, in_valid, load, overlap_en, clr_cnt;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] pat_len;

    logic       out_a, sat_a, err_a;
    logic [7:0] cnt_a;
    logic       out_b, sat_b, err_b;
    logic [1:0] cnt_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_in(in_b), .i_in_valid(in_valid), .i_load(load),
        .i_pat(pat), .i_pat_len(pat_len), .i_overlap_en(overlap_en), .i_clr_cnt(clr_cnt),
        .o_out(out_a), .o_match_cnt(cnt_a), .o_cnt_sat(sat_a), .o_cfg_err(err_a)
    );

    seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_in(in_b), .i_in_valid(in_valid), .i_load(load),
        .i_pat(pat), .i_pat_len(pat_len), .i_overlap_en(overlap_en), .i_clr_cnt(clr_cnt),
        .o_out(out_b), .o_match_cnt(cnt_b), .o_cnt_sat(sat_b), .o_cfg_err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic b, input logic v);
        in_b = b; in_valid = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic do_load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        pat = p; pat_len = l; overlap_en = o; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic do_clr();
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
    endtask

    // bits[n-1] is sent first; exp[n-1] is the out value expected after it.
    task automatic stream(input string tag, input logic [15:0] bits, input int n,
                          input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            tick(bits[i], 1'b1);
            chk($sformatf("%s_bit%0d", tag, n - i), {31'd0, out_a}, {31'd0, exp[i]});
        end
    endtask

    initial begin
        rst = 1'b0; in_b = 1'b0; in_valid = 1'b0; load = 1'b0;
        overlap_en = 1'b0; clr_cnt = 1'b0; pat = '0; pat_len = '0;
        @(posedge clk); #1;
        do_reset();
        chk("rst_out", {31'd0, out_a}, 32'd0);
        chk("rst_cnt", {24'd0, cnt_a}, 32'd0);
        chk("rst_sat", {31'd0, sat_a}, 32'd0);
        chk("rst_err", {31'd0, err_a}, 32'd1);

        // 1: overlapping 10110
        do_load(8'b00010110, 4'd5, 1'b1);
        chk("t1_err", {31'd0, err_a}, 32'd0);
        stream("t1", 16'b10110110, 8, 16'b00001001);
        chk("t1_cnt", {24'd0, cnt_a}, 32'd2);

        // 2: non-overlapping; load keeps the count, clr zeroes it
        do_load(8'b00010110, 4'd5, 1'b0);
        chk("t2_cnt_kept", {24'd0, cnt_a}, 32'd2);
        do_clr();
        chk("t2_cnt_clr", {24'd0, cnt_a}, 32'd0);
        stream("t2", 16'b10110110, 8, 16'b00001000);
        chk("t2_cnt", {24'd0, cnt_a}, 32'd1);

        // 3: pattern 11, both overlap modes
        do_load(8'b00000011, 4'd2, 1'b1);
        do_clr();
        stream("t3o", 16'b1111, 4, 16'b0111);
        chk("t3o_cnt", {24'd0, cnt_a}, 32'd3);
        do_load(8'b00000011, 4'd2, 1'b0);
        do_clr();
        stream("t3n", 16'b1111, 4, 16'b0101);
        chk("t3n_cnt", {24'd0, cnt_a}, 32'd2);

        // 4: valid gaps; upper pattern bits are don't-care
        do_load(8'b11110110, 4'd5, 1'b1);
        do_clr();
        stream("t4a", 16'b101, 3, 16'b000);
        for (int g = 0; g < 3; g++) begin
            tick(1'b1, 1'b0);
            chk($sformatf("t4_gap%0d", g), {31'd0, out_a}, 32'd0);
        end
        stream("t4b", 16'b10, 2, 16'b01);
        chk("t4_cnt", {24'd0, cnt_a}, 32'd1);

        // 5: saturation on the 2-bit counter, then clear vs increment
        do_load(8'b00000001, 4'd1, 1'b1);
        do_clr();
        for (int k = 1; k <= 6; k++) begin
            tick(1'b1, 1'b1);
            chk($sformatf("t5_out%0d", k), {31'd0, out_b}, 32'd1);
            chk($sformatf("t5_cnt%0d", k), {30'd0, cnt_b}, (k < 3) ? k : 3);
            chk($sformatf("t5_sat%0d", k), {31'd0, sat_b}, (k >= 3) ? 1 : 0);
        end
        clr_cnt = 1'b1;
        tick(1'b1, 1'b1);
        clr_cnt = 1'b0;
        chk("t5_clr_out", {31'd0, out_b}, 32'd1);
        chk("t5_clr_cnt", {30'd0, cnt_b}, 32'd0);
        chk("t5_clr_sat", {31'd0, sat_b}, 32'd0);

        // 6: reset mid-pattern, then invalid lengths
        do_load(8'b00010110, 4'd5, 1'b1);
        stream("t6a", 16'b1011, 4, 16'b0000);
        do_reset();
        chk("t6_rst_err", {31'd0, err_a}, 32'd1);
        chk("t6_rst_cnt", {24'd0, cnt_a}, 32'd0);
        do_load(8'b00010110, 4'd5, 1'b1);
        stream("t6b", 16'b0, 1, 16'b0);
        do_load(8'b00010110, 4'd0, 1'b1);
        chk("t6_len0_err", {31'd0, err_a}, 32'd1);
        stream("t6c", 16'b10110, 5, 16'b00000);
        do_load(8'b00010110, 4'd9, 1'b1);
        chk("t6_len9_err", {31'd0, err_a}, 32'd1);
        stream("t6d", 16'b10110, 5, 16'b00000);
        chk("t6_cnt", {24'd0, cnt_a}, 32'd0);
        do_load(8'b00010110, 4'd8, 1'b1);
        chk("t6_len8_err", {31'd0, err_a}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
